// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader FSM state encoding and the stream header layout.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        LOAD,
        FIN,
        DONE,
        ERR
    } state_t;

    // The stream header is a little-endian 16-bit word count.
    localparam int HDR_BYTES = 2;
    localparam int N_W       = 8 * HDR_BYTES;

    function automatic logic accepts_bytes(state_t s);
        return (s == HDR0) || (s == HDR1) || (s == LOAD);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader is the slave of the stream and the master of the write port.
interface prog_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/byte_packer.sv
// Little-endian 4-byte word assembler: the first byte of each group lands in word[7:0].
// word_valid pulses combinationally while the 4th byte of a word is being accepted.
module byte_packer (
    input  logic        clk,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_data, shift_q[23:8]};
        end
    end

    // After three bytes shift_q is {b2, b1, b0}; the live 4th byte completes the word.
    assign word_valid = byte_valid && (cnt_q == 2'd3);
    assign word       = {byte_data, shift_q};

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a word-count header, writes the image into
// instruction memory word by word and holds the core in reset until it is complete.
module prog_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus,
    output logic          core_reset,
    output logic          done,
    output logic          err
);

    localparam int K_W = $clog2(DEPTH_WORDS + 1);

    state_t         state_q, state_d;
    logic [N_W-1:0] n_q;
    logic [N_W-1:0] n_full;
    logic [K_W-1:0] k_q;
    logic           xfer;
    logic           load_xfer;
    logic           word_valid;
    logic           last_word;
    logic [31:0]    word;

    assign xfer      = bus.in_valid & bus.in_ready;
    assign load_xfer = xfer && (state_q == LOAD);
    assign n_full    = {bus.in_data, n_q[7:0]};
    assign last_word = word_valid && ((N_W'(k_q) + N_W'(1)) == n_q);

    byte_packer u_packer (
        .clk        (clk),
        .clear      (reset),
        .byte_valid (load_xfer),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= HDR0;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HDR0: if (xfer) state_d = HDR1;
            HDR1: begin
                if (xfer) begin
                    if (n_full == '0)                    state_d = FIN;
                    else if (n_full > N_W'(DEPTH_WORDS)) state_d = ERR;
                    else                                 state_d = LOAD;
                end
            end
            LOAD: if (last_word) state_d = FIN;
            FIN:  state_d = DONE;
            DONE: state_d = DONE;
            ERR:  state_d = ERR;
            default: state_d = HDR0;
        endcase
    end

    // Header, word counter and all outputs are registered; outputs follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q            <= '0;
            k_q            <= '0;
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_reset     <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            if (xfer && state_q == HDR0) n_q[7:0]     <= bus.in_data;
            if (xfer && state_q == HDR1) n_q[N_W-1:8] <= bus.in_data;
            if (word_valid) begin
                k_q            <= k_q + K_W'(1);
                bus.imem_addr  <= 32'(k_q) << 2;
                bus.imem_wdata <= word;
            end
            bus.imem_we  <= word_valid;
            bus.in_ready <= accepts_bytes(state_d);
            core_reset   <= (state_d != DONE);
            done         <= (state_d == DONE);
            err          <= (state_d == ERR);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares them on every imem_we strobe.
module tb_prog_loader;

    logic clk = 1'b0;
    logic reset;
    logic core_reset, done, err;

    always #5 clk = ~clk;

    prog_loader_if bus ();

    prog_loader #(.DEPTH_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          tests   = 0;
    int          fails   = 0;
    int          strobes = 0;
    logic        prev_we = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must be single-cycle and match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            strobes++;
            check("we_width", 32'(prev_we), 32'd0);
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("imem_addr", bus.imem_addr, e.addr);
                check("imem_wdata", bus.imem_wdata, e.data);
            end
            last_addr = bus.imem_addr;
            last_data = bus.imem_wdata;
        end
        prev_we = bus.imem_we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Sends header n and the words in img; the last byte is followed by no gap,
    // so the task returns in the FIN cycle.
    task automatic send_image(input logic [15:0] n, input int gap);
        logic [31:0] w;
        send_byte(n[7:0], gap);
        send_byte(n[15:8], (img.size() == 0) ? 0 : gap);
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            exp_q.push_back('{addr: 32'(i) * 32'd4, data: w});
            for (int j = 0; j < 4; j++)
                send_byte(w[8*j +: 8], (i == img.size() - 1 && j == 3) ? 0 : gap);
        end
    endtask

    task automatic do_reset(input logic with_valid);
        reset        = 1'b1;
        bus.in_valid = with_valid;
        bus.in_data  = 8'hAA;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'd0);
        check("rst_imem_wdata", bus.imem_wdata, 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        strobes = 0;
    endtask

    // Called in the FIN cycle of an image that ends in a write.
    task automatic check_finish(input string tag, input int n_words);
        check({tag, "_fin_we"}, 32'(bus.imem_we), 32'd1);
        check({tag, "_fin_core_reset"}, 32'(core_reset), 32'd1);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd0);
        check({tag, "_we_after"}, 32'(bus.imem_we), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        // Bytes offered after completion must not be consumed or written.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (6) @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_strobes"}, 32'(strobes), 32'(n_words));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_done_hold"}, 32'(done), 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        do_reset(1'b0);

        // Two-word image at full rate.
        img = {32'h00A00513, 32'h00B00593};
        send_image(16'd2, 0);
        check_finish("full_rate", 2);

        // Same image with a 3-cycle bubble after every byte.
        do_reset(1'b0);
        send_image(16'd2, 3);
        check_finish("gapped", 2);

        // Empty image: FIN then DONE with no writes.
        do_reset(1'b0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("n0_fin_done", 32'(done), 32'd0);
        check("n0_fin_core_reset", 32'(core_reset), 32'd1);
        @(negedge clk);
        check("n0_done", 32'(done), 32'd1);
        check("n0_core_reset", 32'(core_reset), 32'd0);
        check("n0_strobes", 32'(strobes), 32'd0);

        // Oversized header: N = 65.
        do_reset(1'b0);
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_in_ready", 32'(bus.in_ready), 32'd0);
        check("ovf_core_reset", 32'(core_reset), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h13;
        repeat (8) @(negedge clk);
        bus.in_valid = 1'b0;
        check("ovf_strobes", 32'(strobes), 32'd0);
        check("ovf_err_hold", 32'(err), 32'd1);
        check("ovf_done", 32'(done), 32'd0);

        // Reset in the middle of the second word of a 3-word image.
        do_reset(1'b0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        exp_q.push_back('{addr: 32'h0, data: 32'h44332211});
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        check("midrst_strobes", 32'(strobes), 32'd1);
        do_reset(1'b1);
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        img = {32'hDEADBEEF};
        send_image(16'd1, 0);
        check_finish("after_rst", 1);

        // Full-capacity image.
        do_reset(1'b0);
        img.delete();
        for (int k = 0; k < 64; k++) img.push_back(32'hC0DE0000 + 32'(k));
        send_image(16'd64, 0);
        check_finish("n64", 64);
        check("n64_last_addr", last_addr, 32'h000000FC);
        check("n64_last_data", last_data, 32'hC0DE003F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the instruction memory of the 5-stage pipeline. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them sequentially into instruction memory. The core is held in reset until the whole image is loaded, then released. It stalls the stream and flags an error if the image is oversized.

## Interface
- `DEPTH_WORDS`, 64: instruction memory capacity in 32-bit words.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte; a transfer occurs on an edge with `in_valid & in_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  32  byte address of the word being written, always a multiple of 4.
- `imem_wdata`  out  32  word to write.
- `core_reset`  out  1  reset to the pipeline top; high until load completes.
- `done`  out  1  image fully written.
- `err`  out  1  header word count exceeds `DEPTH_WORDS`.

## Operation
- Stream format: 2-byte header N (little-endian, first byte = N[7:0]), then 4·N payload bytes, each word little-endian (first byte → `wdata[7:0]`).
- States: HDR0, HDR1, LOAD, FIN, DONE, ERR.
  - HDR0: capture N[7:0] on transfer, go to HDR1.
  - HDR1: capture N[15:8] on transfer. If N = 0, go to FIN. If N > `DEPTH_WORDS`, go to ERR. Otherwise go to LOAD.
  - LOAD: byte counter 0..3 with a byte shifter. On the 4th byte of word k, register `imem_we`=1, `imem_addr`=4·k, `imem_wdata`=assembled word, and increment k. When k reaches N, go to FIN.
  - FIN: one cycle.
  - DONE: terminal; `done`=1 and `core_reset`=0.
  - ERR: terminal; `err`=1 and `core_reset` stays 1.
- `in_ready`=1 in HDR0, HDR1 and LOAD; 0 in FIN, DONE and ERR. Bytes presented in those states are not consumed.
- Word index k has width clog2(`DEPTH_WORDS`+1). Address is k·4, zero-extended to 32 bits.
- Only `reset` leaves DONE or ERR.

## Timing
- Reset values: state HDR0, `in_ready`=0 during reset then 1 from the first cycle after, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset`=1, `done`=0, `err`=0. The byte counter, k and N are all cleared.
- All outputs are registered.
- `imem_we` is high for exactly the cycle after the edge that accepted a word's 4th byte. Address and data are stable in that same cycle.
- Back-to-back bytes at full rate are supported. Minimum spacing between write strobes is 4 cycles.
- Final word: the accepting edge enters FIN with `imem_we`=1. The next edge enters DONE, with `imem_we`=0, `done`=1 and `core_reset`=0. Result: `core_reset` falls exactly one cycle after the last write strobe.
- N = 0: `done` rises 2 cycles after the HDR1 transfer edge, with no writes.
- Gaps in `in_valid` hold all state, and the partial word is kept.
- `reset` mid-load takes priority over any transfer on the same edge. The partial word is discarded and no write is issued.

## Structure
- Shared package `loader_pkg`: state enum (HDR0, HDR1, LOAD, FIN, DONE, ERR) and the header byte-count constant (2).
- One sub-module `byte_packer`: 4-byte little-endian shift assembler with a 2-bit counter and a `word_valid` pulse. It has its own synchronous clear, driven by `reset`.
- The FSM, word counter and output registers live in `prog_loader`.

## Test plan
- N=2, bytes 02 00 13 05 A0 00 93 05 B0 00 at full rate: expect two strobes.
  - First: `imem_addr`=0x0, `imem_wdata`=0x00A00513.
  - Second: `imem_addr`=0x4, `imem_wdata`=0x00B00593.
  - `core_reset` falls 1 cycle after the 2nd strobe; `done`=1.
- Same image with `in_valid` low for 3 cycles between every byte: identical writes and data. Strobe count = 2, each exactly 1 cycle wide.
- Header 00 00: no `imem_we`; `done`=1 and `core_reset`=0 two cycles after the 2nd header byte.
- Header 41 00 (N=65 > 64): `err`=1, `in_ready`=0, `core_reset` stays 1. Further bytes produce no writes.
- Header 03 00, then 6 payload bytes, then `reset` asserted together with `in_valid` for 1 cycle:
  - Only the word at addr 0 is written.
  - After reset, state is HDR0 and outputs equal their reset values.
  - A fresh N=1 image writes its word to addr 0.
- N=64 image with word k = 0xC0DE0000+k: the last strobe has `imem_addr`=0xFC and data 0xC0DE003F. No 65th strobe; `done`=1.
